// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package pipe_pkg;

    // Per-stage fill level: EMPTY (no beat), HALF (main only), FULL (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Bits needed to count 0..2*stages stored beats.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One elastic stage: main register plus skid register behind a valid/ready handshake.
// Latency: a beat accepted at a posedge is presented on out_* right after that edge.
// Backpressure: in_ready comes from registered state only (not FULL); the skid absorbs one stalled beat.
// Ports: clk, reset (async, active-high), flush (sync clear),
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    stage_state_t     state_q, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             s_in, s_out;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign s_in  = in_valid & in_ready;
    assign s_out = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Stored data is left as-is; it is unreachable once the state is EMPTY.
            state_nxt = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (s_in) begin
                        state_nxt = HALF;
                        main_nxt  = in_data;
                    end
                end
                HALF: begin
                    if (s_in && s_out) begin
                        main_nxt = in_data;
                    end else if (s_in) begin
                        state_nxt = FULL;
                        skid_nxt  = in_data;
                    end else if (s_out) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no upstream beat can arrive.
                    if (s_out) begin
                        state_nxt = HALF;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_elastic_reg.sv
// Chain of STAGES elastic skid stages with occupancy count, synchronous flush and zero-gated output.
// Latency: STAGES cycles from acceptance to out_valid on an empty chain; 1 beat/cycle sustained.
// Backpressure: holds up to 2*STAGES beats; in_ready is registered, never combinational from out_ready.
// Ports: clk, reset (async, active-high), flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data,
//        occupancy (stored beats across all stages).
module pipe_elastic_reg
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 1,
    localparam int OCC_W  = occ_width(STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy
);

    // Link i feeds stage i; link STAGES is the chain output.
    logic             link_vld [0:STAGES];
    logic             link_rdy [0:STAGES];
    logic [WIDTH-1:0] link_dat [0:STAGES];

    logic             in_xfer, out_xfer;
    logic [OCC_W-1:0] occ_q;

    assign link_vld[0]      = in_valid;
    assign link_dat[0]      = in_data;
    assign in_ready         = link_rdy[0];
    assign link_rdy[STAGES] = out_ready;
    assign out_valid        = link_vld[STAGES];
    assign out_data         = link_vld[STAGES] ? link_dat[STAGES] : '0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (link_vld[i]),
            .in_data   (link_dat[i]),
            .in_ready  (link_rdy[i]),
            .out_valid (link_vld[i+1]),
            .out_data  (link_dat[i+1]),
            .out_ready (link_rdy[i+1])
        );
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Tracks only chain-boundary transfers, so it equals the sum of per-stage entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
module tb_pipe_elastic_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Three chains: index 0 -> STAGES=2, 1 -> STAGES=1, 2 -> STAGES=4.
    int          stg [3] = '{2, 1, 4};
    logic        iv   [3];
    logic [31:0] idat [3];
    logic        ordy [3];
    logic        fl   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic [31:0] od   [3];
    logic [3:0]  occ  [3];
    logic [2:0]  occ0;
    logic [1:0]  occ1;
    logic [3:0]  occ2;

    assign occ[0] = {1'b0, occ0};
    assign occ[1] = {2'b00, occ1};
    assign occ[2] = occ2;

    pipe_elastic_reg #(.WIDTH(32), .STAGES(2)) u_dut2 (
        .clk(clk), .reset(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
        .occupancy(occ0)
    );
    pipe_elastic_reg #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .reset(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
        .occupancy(occ1)
    );
    pipe_elastic_reg #(.WIDTH(32), .STAGES(4)) u_dut4 (
        .clk(clk), .reset(rst), .flush(fl[2]),
        .in_valid(iv[2]), .in_data(idat[2]), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ready(ordy[2]),
        .occupancy(occ2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of beats accepted but not yet delivered, plus a log of deliveries.
    logic [31:0] mq[$];
    logic [31:0] popped[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks done at every negedge against the model FIFO.
    task automatic post_checks(input int d);
        check_eq("occupancy", 64'(occ[d]), 64'(mq.size()));
        if (!ov[d]) check_eq("gated_data", 64'(od[d]), 64'd0);
        if (mq.size() == 0) begin
            check_eq("empty_valid", 64'(ov[d]), 64'd0);
            check_eq("empty_ready", 64'(ir[d]), 64'd1);
        end else if (ov[d]) begin
            check_eq("head_data", 64'(od[d]), 64'(mq[0]));
        end
        if (mq.size() == 2 * stg[d]) check_eq("full_ready", 64'(ir[d]), 64'd0);
    endtask

    // Called at a negedge: drive inputs for one cycle, update model, advance to next negedge.
    task automatic step(input int d, input bit v, input logic [31:0] dat, input bit o, input bit f);
        bit inx, outx;
        iv[d]   = v;
        idat[d] = dat;
        ordy[d] = o;
        fl[d]   = f;
        inx  = v && ir[d];
        outx = ov[d] && o;
        if (outx) begin
            popped.push_back(od[d]);
            if (mq.size() > 0) void'(mq.pop_front());
        end
        if (f) mq.delete();
        else if (inx) mq.push_back(dat);
        @(posedge clk);
        @(negedge clk);
        post_checks(d);
    endtask

    initial begin
        int acc;
        int cyc;
        bit v, o;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; idat[k] = '0; ordy[k] = 1'b0; fl[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state of every chain.
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_out_valid", 64'(ov[k]), 64'd0);
            check_eq("rst_out_data", 64'(od[k]), 64'd0);
            check_eq("rst_in_ready", 64'(ir[k]), 64'd1);
            check_eq("rst_occupancy", 64'(occ[k]), 64'd0);
        end

        // Back-to-back stream with out_ready held high (STAGES=2).
        mq.delete(); popped.delete();
        for (int i = 1; i <= 8; i++) begin
            step(0, 1'b1, 32'(i), 1'b1, 1'b0);
            check_eq("b2b_in_ready", 64'(ir[0]), 64'd1);
            if (i == 1) check_eq("lat_early_valid", 64'(ov[0]), 64'd0);
            if (i == 2) begin
                check_eq("lat_valid", 64'(ov[0]), 64'd1);
                check_eq("lat_data", 64'(od[0]), 64'd1);
            end
            if (i >= 2) check_eq("b2b_occupancy", 64'(occ[0]), 64'd2);
        end
        repeat (6) step(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("b2b_count", 64'(popped.size()), 64'd8);
        for (int i = 0; i < popped.size(); i++) check_eq("b2b_order", 64'(popped[i]), 64'(i + 1));

        // Fill under back-pressure, then drain.
        mq.delete(); popped.delete();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (ir[0]) acc++;
            step(0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            if (i == 3) check_eq("bp_ready_after_fill", 64'(ir[0]), 64'd0);
        end
        check_eq("bp_accepted", 64'(acc), 64'd4);
        check_eq("bp_occupancy", 64'(occ[0]), 64'd4);
        check_eq("bp_in_ready", 64'(ir[0]), 64'd0);
        cyc = 0;
        while (mq.size() > 0 && cyc < 20) begin
            step(0, 1'b0, 32'd0, 1'b1, 1'b0);
            cyc++;
        end
        check_eq("bp_drain_count", 64'(popped.size()), 64'd4);
        for (int i = 0; i < popped.size(); i++) check_eq("bp_order", 64'(popped[i]), 64'hA0 + 64'(i));

        // Flush with a simultaneous upstream offer.
        mq.delete(); popped.delete();
        for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
        check_eq("pre_flush_occ", 64'(occ[0]), 64'd3);
        step(0, 1'b1, 32'hDEAD, 1'b0, 1'b1);
        check_eq("flush_occ", 64'(occ[0]), 64'd0);
        check_eq("flush_valid", 64'(ov[0]), 64'd0);
        check_eq("flush_data", 64'(od[0]), 64'd0);
        fl[0] = 1'b0;
        repeat (5) step(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("flush_no_beats", 64'(popped.size()), 64'd0);

        // Asynchronous reset in the middle of a burst.
        mq.delete(); popped.delete();
        for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h50 + 32'(i), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", 64'(ov[0]), 64'd0);
        check_eq("arst_data", 64'(od[0]), 64'd0);
        check_eq("arst_occ", 64'(occ[0]), 64'd0);
        check_eq("arst_ready", 64'(ir[0]), 64'd1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        popped.delete();
        for (int i = 0; i < 6; i++) step(0, 1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
        repeat (6) step(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("post_rst_count", 64'(popped.size()), 64'd6);
        for (int i = 0; i < popped.size(); i++) check_eq("post_rst_order", 64'(popped[i]), 64'h10 + 64'(i));

        // Random valid/ready traffic on the STAGES=1 and STAGES=4 chains.
        for (int d = 1; d < 3; d++) begin
            mq.delete(); popped.delete();
            acc = 0;
            cyc = 0;
            while (acc < 5000 && cyc < 30000) begin
                v = ($urandom_range(0, 3) != 0);
                o = ($urandom_range(0, 3) != 0);
                if (v && ir[d]) acc++;
                step(d, v, $urandom, o, 1'b0);
                cyc++;
            end
            check_eq("rand_budget", 64'(acc >= 5000), 64'd1);
            cyc = 0;
            while (mq.size() > 0 && cyc < 100) begin
                step(d, 1'b0, 32'd0, 1'b1, 1'b0);
                cyc++;
            end
            check_eq("rand_drained", 64'(mq.size()), 64'd0);
            check_eq("rand_delivered", 64'(popped.size()), 64'(acc));
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
